trap_controller: RTL

- Sits directly downstream of the exception priority encoder.
- Consumes its excCaught, exception code, faulting address and faulting instruction.
- Captures the first exception into cause/EPC/TVAL registers, flushes the pipeline for a fixed number of cycles, then redirects fetch to the trap vector.
- Tracks handler execution, supports trap return to the saved EPC, and escalates a nested exception to a latched double-fault that only the host can clear.

---
 rtl/trap_controller.sv | 124 ++++++++++++
 1 files changed

// File: rtl/trap_controller.sv
// Trap controller: captures the first exception, flushes the pipeline, redirects
// fetch to the trap vector, tracks the handler and escalates nested exceptions.
module trap_controller #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [63:0] TRAP_VECTOR  = 64'h0000_0000_0000_0100,
  parameter int          COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   excCaught,
  input  logic [4:0]             exception,
  input  logic [63:0]            badAddress,
  input  logic [63:0]            badInstruction,
  input  logic                   trapReturn,
  input  logic                   hostClear,
  output logic                   flush,
  output logic                   stall,
  output logic                   pcRedirect,
  output logic [63:0]            redirectPC,
  output logic                   inTrap,
  output logic                   doubleFault,
  output logic [4:0]             causeReg,
  output logic [63:0]            epcReg,
  output logic [63:0]            tvalReg,
  output logic [COUNT_WIDTH-1:0] excCount
);

  typedef enum logic [2:0] {
    stRun,
    stFlush,
    stRedirect,
    stHandler,
    stReturn,
    stFault
  } stateT;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  stateT      state;
  stateT      nextState;
  logic [3:0] flushCnt;
  logic       capture;
  logic       countExc;
  logic       clearCapture;

  function automatic logic [COUNT_WIDTH-1:0] satInc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    nextState = state;
    unique case (state)
      stRun:      if (excCaught) nextState = stFlush;
      stFlush:    if (flushCnt == 4'd0) nextState = stRedirect;
      stRedirect: nextState = stHandler;
      stHandler: begin
        // A nested exception outranks a simultaneous trap return.
        if (excCaught)       nextState = stFault;
        else if (trapReturn) nextState = stReturn;
      end
      stReturn:   nextState = stRun;
      stFault:    if (hostClear) nextState = stRun;
      default:    nextState = stRun;
    endcase
  end

  assign capture      = (state == stRun) && excCaught;
  assign countExc     = excCaught && ((state == stRun) || (state == stHandler));
  assign clearCapture = (state == stFault) && hostClear;

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= stRun;
      flushCnt    <= 4'd0;
      causeReg    <= '0;
      epcReg      <= '0;
      tvalReg     <= '0;
      excCount    <= '0;
      flush       <= 1'b0;
      stall       <= 1'b0;
      pcRedirect  <= 1'b0;
      redirectPC  <= '0;
      inTrap      <= 1'b0;
      doubleFault <= 1'b0;
    end else begin
      state <= nextState;

      if (capture)
        flushCnt <= FLUSH_LOAD;
      else if ((state == stFlush) && (flushCnt != 4'd0))
        flushCnt <= flushCnt - 4'd1;

      if (capture) begin
        causeReg <= exception;
        epcReg   <= badAddress;
        tvalReg  <= badInstruction;
      end else if (clearCapture) begin
        causeReg <= '0;
        epcReg   <= '0;
        tvalReg  <= '0;
      end

      if (countExc)
        excCount <= satInc(excCount);

      flush       <= (nextState == stFlush);
      stall       <= (nextState == stFlush) || (nextState == stRedirect) ||
                     (nextState == stReturn) || (nextState == stFault);
      pcRedirect  <= (nextState == stRedirect) || (nextState == stReturn);
      inTrap      <= (nextState == stHandler) || (nextState == stReturn);
      doubleFault <= (nextState == stFault);

      // epcReg cannot change while in the handler, so its current value is the return target.
      if (nextState == stRedirect)
        redirectPC <= TRAP_VECTOR;
      else if (nextState == stReturn)
        redirectPC <= epcReg;
      else
        redirectPC <= '0;
    end
  end

endmodule
